// File: rtl/mnist_pixel_streamer.sv
// ============================================================================
// mnist_pixel_streamer
//   Streams NUM_IMAGES grayscale images from a synchronous image ROM to the
//   CNN one pixel per beat in raster order. Each returned digit is compared
//   with its label, and the block keeps a running count of correct results.
//   Optional result watchdog: define STREAMER_TIMEOUT_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mnist_pixel_streamer #(
    parameter int GS_BITS        = 8,
    parameter int BCD_BITS       = 4,
    parameter int IMG_PIXELS     = 784,
    parameter int NUM_IMAGES     = 16,
    parameter int IMG_ADDR_BITS  = 14,
    parameter int LBL_ADDR_BITS  = 4,
    parameter int PIXEL_GAP      = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IMG_ADDR_BITS-1:0] img_addr,
    input  logic [GS_BITS-1:0]       img_q,
    output logic [LBL_ADDR_BITS-1:0] lbl_addr,
    input  logic [BCD_BITS-1:0]      lbl_q,
    output logic [GS_BITS-1:0]       pixel_o,
    output logic                     pixel_o_valid,
    input  logic [BCD_BITS-1:0]      digit_i,
    input  logic                     digit_i_valid,
    output logic [BCD_BITS-1:0]      result_digit,
    output logic                     result_match,
    output logic                     result_valid,
    output logic [LBL_ADDR_BITS:0]   correct_cnt,
    output logic                     timeout_err
);

    localparam int PIX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int GAP_W = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;
    localparam int CNT_W = LBL_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STREAM   = 3'd1,
        S_DRAIN    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_NEXT     = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t                     state_q;
    logic [IMG_ADDR_BITS-1:0]   base_q;
    logic [PIX_W-1:0]           pix_q;
    logic [GAP_W-1:0]           gap_q;
    logic [LBL_ADDR_BITS-1:0]   idx_q;
    logic [BCD_BITS-1:0]        label_q;
    logic                       vld_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       res_valid_q;
    logic                       res_match_q;
    logic [BCD_BITS-1:0]        res_digit_q;
    logic [CNT_W-1:0]           correct_q;
    logic                       issue;
    logic                       digit_match;

`ifdef STREAMER_TIMEOUT_EN
    logic [31:0]                to_q;
    logic                       timeout_err_q;
    assign timeout_err = timeout_err_q;
`else
    logic                       unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign timeout_err        = 1'b0;
`endif

    // An address is issued whenever streaming and the inter-pixel gap has elapsed
    assign issue       = (state_q == S_STREAM) && (gap_q == '0);
    // Digits outside 0..9 can never be a correct classification
    assign digit_match = (digit_i == label_q) && (digit_i < BCD_BITS'(10));

    assign img_addr      = base_q + IMG_ADDR_BITS'(pix_q);
    assign lbl_addr      = idx_q;
    assign pixel_o       = vld_q ? img_q : '0;
    assign pixel_o_valid = vld_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign result_digit  = res_digit_q;
    assign result_match  = res_match_q;
    assign result_valid  = res_valid_q;
    assign correct_cnt   = correct_q;

    // Label ROM output is registered so the compare has a full cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            label_q <= '0;
        end else begin
            label_q <= lbl_q;
        end
    end

    // Run sequencer: address issue, result capture and image stepping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            pix_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_digit_q <= '0;
            correct_q   <= '0;
`ifdef STREAMER_TIMEOUT_EN
            to_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // ROM data for an issued address appears one cycle later
            vld_q       <= issue;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        pix_q     <= '0;
                        base_q    <= '0;
                        gap_q     <= '0;
                        correct_q <= '0;
`ifdef STREAMER_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                        state_q   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        if (pix_q == PIX_W'(IMG_PIXELS - 1)) begin
                            gap_q   <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            gap_q <= GAP_W'(PIXEL_GAP);
                            pix_q <= pix_q + PIX_W'(1);
                        end
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                S_DRAIN: begin
`ifdef STREAMER_TIMEOUT_EN
                    to_q <= '0;
`endif
                    state_q <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (digit_i_valid) begin
                        res_digit_q <= digit_i;
                        res_match_q <= digit_match;
                        res_valid_q <= 1'b1;
                        if (digit_match) begin
                            correct_q <= correct_q + CNT_W'(1);
                        end
                        state_q <= S_NEXT;
                    end
`ifdef STREAMER_TIMEOUT_EN
                    else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_q <= 1'b1;
                        res_match_q   <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_NEXT;
                    end else begin
                        to_q <= to_q + 32'd1;
                    end
`endif
                end
                S_NEXT: begin
                    pix_q <= '0;
                    // Last image keeps base/index in range rather than stepping past the end
                    if (idx_q == LBL_ADDR_BITS'(NUM_IMAGES - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + LBL_ADDR_BITS'(1);
                        base_q  <= base_q + IMG_ADDR_BITS'(IMG_PIXELS);
                        state_q <= S_STREAM;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mnist_pixel_streamer.sv
`default_nettype none

module tb_mnist_pixel_streamer;

    localparam int GS   = 8;
    localparam int BCD  = 4;
    localparam int PIX  = 784;
    localparam int NIMG = 2;
    localparam int AW   = 14;
    localparam int LW   = 4;
    localparam int TO   = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_m = 1'b0;
    logic dig_v = 1'b0;
    logic sel = 1'b0;
    logic [BCD-1:0] dig = '0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // DUT 0: back-to-back pixels
    logic busy0, done0, pv0, rv0, rm0, terr0;
    logic [AW-1:0] ia0;
    logic [LW-1:0] la0;
    logic [GS-1:0] iq0, px0;
    logic [BCD-1:0] lq0, rd0;
    logic [LW:0] cnt0;
    logic st0, dv0;
    assign st0 = start_m & ~sel;
    assign dv0 = dig_v & ~sel;

    // DUT 2: two idle cycles after every pixel
    logic busy2, done2, pv2, rv2, rm2, terr2;
    logic [AW-1:0] ia2;
    logic [LW-1:0] la2;
    logic [GS-1:0] iq2, px2;
    logic [BCD-1:0] lq2, rd2;
    logic [LW:0] cnt2;
    logic st2, dv2;
    assign st2 = start_m & sel;
    assign dv2 = dig_v & sel;

    // ROM models: image ROM holds addr[7:0], labels are {3,7}
    always @(posedge clk) begin
        iq0 <= ia0[7:0];
        iq2 <= ia2[7:0];
        lq0 <= (la0 == '0) ? 4'd3 : 4'd7;
        lq2 <= (la2 == '0) ? 4'd3 : 4'd7;
    end

    mnist_pixel_streamer #(
        .GS_BITS(GS), .BCD_BITS(BCD), .IMG_PIXELS(PIX), .NUM_IMAGES(NIMG),
        .IMG_ADDR_BITS(AW), .LBL_ADDR_BITS(LW), .PIXEL_GAP(0), .TIMEOUT_CYCLES(TO)
    ) dut0 (
        .clk(clk), .rst(rst), .start(st0), .busy(busy0), .done(done0),
        .img_addr(ia0), .img_q(iq0), .lbl_addr(la0), .lbl_q(lq0),
        .pixel_o(px0), .pixel_o_valid(pv0), .digit_i(dig), .digit_i_valid(dv0),
        .result_digit(rd0), .result_match(rm0), .result_valid(rv0),
        .correct_cnt(cnt0), .timeout_err(terr0)
    );

    mnist_pixel_streamer #(
        .GS_BITS(GS), .BCD_BITS(BCD), .IMG_PIXELS(PIX), .NUM_IMAGES(NIMG),
        .IMG_ADDR_BITS(AW), .LBL_ADDR_BITS(LW), .PIXEL_GAP(2), .TIMEOUT_CYCLES(TO)
    ) dut2 (
        .clk(clk), .rst(rst), .start(st2), .busy(busy2), .done(done2),
        .img_addr(ia2), .img_q(iq2), .lbl_addr(la2), .lbl_q(lq2),
        .pixel_o(px2), .pixel_o_valid(pv2), .digit_i(dig), .digit_i_valid(dv2),
        .result_digit(rd2), .result_match(rm2), .result_valid(rv2),
        .correct_cnt(cnt2), .timeout_err(terr2)
    );

    // Selected-DUT view used by the scenario tasks
    logic m_busy, m_done, m_pv, m_rv, m_rm, m_terr;
    logic [AW-1:0] m_addr;
    logic [GS-1:0] m_pix;
    logic [BCD-1:0] m_rd;
    logic [LW:0] m_cnt;
    assign m_busy = sel ? busy2 : busy0;
    assign m_done = sel ? done2 : done0;
    assign m_pv   = sel ? pv2   : pv0;
    assign m_rv   = sel ? rv2   : rv0;
    assign m_rm   = sel ? rm2   : rm0;
    assign m_terr = sel ? terr2 : terr0;
    assign m_addr = sel ? ia2   : ia0;
    assign m_pix  = sel ? px2   : px0;
    assign m_rd   = sel ? rd2   : rd0;
    assign m_cnt  = sel ? cnt2  : cnt0;

    // Streams one image, then answers after d WAIT_RES cycles (d<0: never answer).
    // Enters on any negedge before the first beat; leaves on the result_valid negedge.
    task automatic run_image(input int k, input int gap, input int d, input logic [BCD-1:0] dg,
                             input logic exp_m, input int exp_cnt, input bit inject,
                             output int lat);
        int w;
        int err;
        int idle_err;
        logic [AW-1:0] prev;
        w = 0;
        prev = m_addr;
        while (m_pv !== 1'b1 && w < 3000) begin
            prev = m_addr;
            @(negedge clk);
            w++;
        end
        lat = w;
        checks++;
        if (prev !== AW'(k * PIX)) begin
            fails++;
            $display("FAIL img%0d_first_addr: got %0d expected %0d", k, prev, k * PIX);
        end
        err = 0;
        idle_err = 0;
        for (int j = 0; j < PIX; j++) begin
            if (m_pv !== 1'b1 || m_pix !== GS'((k * PIX + j) % 256)) err++;
            if (m_rv !== 1'b0) idle_err++;
            if (inject && j == 400) begin dig = 4'd3; dig_v = 1'b1; start_m = 1'b1; end
            if (inject && j == 401) begin dig_v = 1'b0; start_m = 1'b0; end
            if (j < PIX - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    if (m_pv !== 1'b0 || m_rv !== 1'b0) idle_err++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (err != 0) begin
            fails++;
            $display("FAIL img%0d_beats: %0d bad beats, expected 0", k, err);
        end
        checks++;
        if (idle_err != 0) begin
            fails++;
            $display("FAIL img%0d_stream_idle: %0d stray beats/results, expected 0", k, idle_err);
        end
        idle_err = 0;
        w = 0;
        while (m_rv !== 1'b1 && w < 300) begin
            if (m_pv !== 1'b0) idle_err++;
            if (d >= 0 && w == d) begin dig = dg; dig_v = 1'b1; end
            @(negedge clk);
            w++;
            dig_v = 1'b0;
        end
        checks++;
        if (w != ((d >= 0) ? d + 1 : TO)) begin
            fails++;
            $display("FAIL img%0d_result_delay: got %0d expected %0d", k, w, (d >= 0) ? d + 1 : TO);
        end
        checks++;
        if (idle_err != 0) begin
            fails++;
            $display("FAIL img%0d_wait_beats: %0d beats in WAIT_RES, expected 0", k, idle_err);
        end
        checks++;
        if (m_rm !== exp_m) begin
            fails++;
            $display("FAIL img%0d_result_match: got %b expected %b", k, m_rm, exp_m);
        end
        if (d >= 0) begin
            checks++;
            if (m_rd !== dg) begin
                fails++;
                $display("FAIL img%0d_result_digit: got %0d expected %0d", k, m_rd, dg);
            end
        end
        checks++;
        if (m_cnt !== (LW + 1)'(exp_cnt)) begin
            fails++;
            $display("FAIL img%0d_correct_cnt: got %0d expected %0d", k, m_cnt, exp_cnt);
        end
    endtask

    // Checks the done pulse / busy fall, starting on the last result_valid negedge
    task automatic check_done;
        checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_done: done=%b busy=%b expected done=0 busy=1", m_done, m_busy);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b busy=%b expected done=1 busy=0", m_done, m_busy);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0) begin
            fails++;
            $display("FAIL done_width: done=%b expected 0", m_done);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, ia0, la0, px0, pv0, rd0, rm0, rv0, cnt0, terr0} !== '0) begin
            fails++;
            $display("FAIL reset_dut0: outputs=%h expected 0",
                     {busy0, done0, ia0, la0, px0, pv0, rd0, rm0, rv0, cnt0, terr0});
        end
        checks++;
        if ({busy2, done2, ia2, la2, px2, pv2, rd2, rm2, rv2, cnt2, terr2} !== '0) begin
            fails++;
            $display("FAIL reset_dut2: outputs=%h expected 0",
                     {busy2, done2, ia2, la2, px2, pv2, rd2, rm2, rv2, cnt2, terr2});
        end
        rst = 1'b1;
    endtask

    task automatic test_stream;
        int lat;
        sel = 1'b0;
        pulse_start;
        checks++;
        if (m_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b expected 1", m_busy);
        end
        run_image(0, 0, 5, 4'd3, 1'b1, 1, 1'b1, lat);
        checks++;
        if (lat != 1) begin
            fails++;
            $display("FAIL first_beat_latency: got %0d expected 2 cycles after start", lat + 1);
        end
        run_image(1, 0, 5, 4'd5, 1'b0, 1, 1'b0, lat);
        check_done;
        // A digit in IDLE must not produce a result
        dig = 4'd3;
        dig_v = 1'b1;
        @(negedge clk);
        dig_v = 1'b0;
        checks++;
        if (m_rv !== 1'b0 || m_cnt !== 5'd1) begin
            fails++;
            $display("FAIL idle_digit_ignored: result_valid=%b cnt=%0d expected 0 and 1", m_rv, m_cnt);
        end
    endtask

    task automatic test_pixel_gap;
        int lat;
        sel = 1'b1;
        pulse_start;
        run_image(0, 2, 5, 4'd3, 1'b1, 1, 1'b0, lat);
        run_image(1, 2, 5, 4'd7, 1'b1, 2, 1'b0, lat);
        check_done;
        sel = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        int beats;
        int w;
        sel = 1'b0;
        pulse_start;
        beats = 0;
        w = 0;
        while (beats < 400 && w < 2000) begin
            if (m_pv === 1'b1) beats++;
            @(negedge clk);
            w++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, ia0, la0, px0, pv0, rd0, rm0, rv0, cnt0, terr0} !== '0) begin
            fails++;
            $display("FAIL reset_mid_stream: outputs=%h expected 0",
                     {busy0, done0, ia0, la0, px0, pv0, rd0, rm0, rv0, cnt0, terr0});
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start;
        checks++;
        if (m_addr !== '0 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_addr: addr=%0d busy=%b expected 0 and 1", m_addr, m_busy);
        end
        run_image(0, 0, 5, 4'd3, 1'b1, 1, 1'b0, lat);
        run_image(1, 0, 5, 4'd7, 1'b1, 2, 1'b0, lat);
        check_done;
    endtask

`ifdef STREAMER_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        sel = 1'b0;
        pulse_start;
        run_image(0, 0, -1, 4'd0, 1'b0, 0, 1'b0, lat);
        checks++;
        if (m_terr !== 1'b1) begin
            fails++;
            $display("FAIL timeout_flag: got %b expected 1", m_terr);
        end
        run_image(1, 0, 5, 4'd7, 1'b1, 1, 1'b0, lat);
        checks++;
        if (m_terr !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got %b expected 1", m_terr);
        end
        check_done;
        pulse_start;
        checks++;
        if (m_terr !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear_on_start: got %b expected 0", m_terr);
        end
        run_image(0, 0, TO - 1, 4'd3, 1'b1, 1, 1'b0, lat);
        checks++;
        if (m_terr !== 1'b0) begin
            fails++;
            $display("FAIL timeout_edge_result_wins: got %b expected 0", m_terr);
        end
        run_image(1, 0, 5, 4'd7, 1'b1, 2, 1'b0, lat);
        check_done;
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset;
        test_stream;
        test_pixel_gap;
        test_reset_mid;
`ifdef STREAMER_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
